avalon_fp_mult_mc: RTL and testbench
====================================

Name: avalon_fp_mult_mc

Overview:
Multi-channel Avalon-MM slave wrapping the fully pipelined single-precision fp_mult IP core. NUM_CH independent channels each hold an operand pair, result and status, and share one multiplier pipeline, so up to one issue per cycle. Completion is tracked with a tag pipeline. Result reads on an in-flight channel block via waitrequest. A level interrupt flags completed results. Sits on the Nios II data bus in place of the single-channel multiplier peripheral.

Parameters:
NUM_CH, 4, number of channels (1..16).
LATENCY, 11, fp_mult pipeline depth in cycles; must match the IP configuration.
CH_W, max(1,$clog2(NUM_CH)), derived channel-index width; not overridden.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
avs_s1_address  input  CH_W+3  {channel[CH_W-1:0], reg[2:0]}
avs_s1_read  input  1  Avalon read strobe
avs_s1_write  input  1  Avalon write strobe
avs_s1_writedata  input  32  write data
avs_s1_readdata  output  32  read data, valid when read && !waitrequest
avs_s1_waitrequest  output  1  stall, combinational
ins_irq  output  1  interrupt, high while any enabled channel has done=1

Behaviour:
- One clock (clk). Reset is synchronous, active-low. While reset=0 at a clk edge:
  - all op1/op2/result regs go to 0; status, done, pending and irq_en go to 0; all tag-pipeline valid bits go to 0.
  - In-flight multiplies are discarded.
  - Outputs: readdata=0, waitrequest=0, ins_irq=0.
- Register map per channel:
  - reg0 op1: R/W.
  - reg1 op2: R/W.
  - reg2 ctrl:
    - Write bit0=1 issues a multiply. Write bit1 sets irq_en.
    - Read returns {29'b0, irq_en, done, pending}.
  - reg3 result: RO.
  - reg4 status: RO, code in [2:0] = 0 none, 1 overflow, 2 underflow, 3 zero, 4 nan.
    - Priority when several flags are set: nan > overflow > underflow > zero.
  - reg5-7: read 0, writes ignored.
  - Channel index >= NUM_CH: reads 0, writes ignored, never stalls.
- Issue:
  - An accepted ctrl write with bit0=1 on channel c, at edge E0, sets pending[c] and loads issue register {valid=1, ch=c, a=op1[c], b=op2[c]}.
  - Operands that are written in the same access cycle are not included. The op regs in effect before E0 are used.
  - The issue register drives fp_mult dataa/datab in the cycle after E0. clk_en is tied 1.
- Tag pipeline:
  - {valid, ch} shifts LATENCY stages in step with fp_mult.
  - On the edge where the tag emerges (E0+LATENCY+1), result[ch] and status[ch] load from fp_mult. done[ch] is set and pending[ch] is cleared.
- waitrequest = 1 iff either:
  - read of reg3 on a channel with pending=1, or
  - write to reg2 with bit0=1 on a channel with pending=1.
  - The stall holds until the completion edge. The access is accepted in the first cycle pending is observed 0.
  - All other accesses have zero wait states.
- An accepted reg3 read returns the new result and clears done[c] on that edge. Status reads do not clear done.
- Simultaneous events:
  - Issue on channel a and completion on channel b in the same cycle are both applied.
  - Completion and result read on the same channel: the completion wins and done stays 1. This cannot coincide with an accepted read, because the read stalls.
  - Re-issue while done=1 (result unread) is allowed. It clears done at issue.
- ins_irq = OR over c of (done[c] && irq_en[c]), registered (1-cycle delay from the done edge).
- Back-to-back issues on different channels in consecutive cycles complete in consecutive cycles in issue order.

Test Plan:
1. Reset, then read every reg of ch0..3 -> all 0, waitrequest=0, ins_irq=0.
2. ch0 op1=0x40000000, op2=0x40400000, ctrl=1, then immediately read ch0 reg3 -> waitrequest high until E0+LATENCY+1, then readdata=0x40C00000, status=0. ctrl read afterwards shows done=0.
3. Issue ch0..ch3 on 4 consecutive cycles: (1.5×2.0=0x40400000), (0×5.0=0x00000000, status 3), (0x7FC00000×1.0 → nan, status 4), (0x7F000000×0x7F000000 → overflow, status 1). Each result lands one cycle apart, and reads never stall after the last completion.
4. ch1 irq_en=1 with an issue -> ins_irq rises one cycle after completion. Reading reg3 -> ins_irq falls the next cycle. Repeat with irq_en=0 -> ins_irq stays 0.
5. Issue ch2, then write ctrl=1 to ch2 while pending -> waitrequest high until the first completes. The second issue uses the current op regs and completes LATENCY+1 edges after its acceptance.
6. Issue ch0, then assert reset=0 for one cycle mid-flight -> no completion ever appears, ch0 pending=0, done=0, result=0. A read of reg3 does not stall. Address reg6 and, if NUM_CH=3, channel 3 read 0.

Source files
------------

// File: rtl/avalon_fp_mult_mc_if.sv
// Avalon-MM slave bus bundle for the multi-channel fp multiplier.
// The address carries {channel, reg[2:0]}.
interface avalon_fp_mult_mc_if #(
    parameter int unsigned CH_W = 2
);
    logic [CH_W+2:0] avs_s1_address;
    logic            avs_s1_read;
    logic            avs_s1_write;
    logic [31:0]     avs_s1_writedata;
    logic [31:0]     avs_s1_readdata;
    logic            avs_s1_waitrequest;

    modport master (
        output avs_s1_address,
        output avs_s1_read,
        output avs_s1_write,
        output avs_s1_writedata,
        input  avs_s1_readdata,
        input  avs_s1_waitrequest
    );

    modport slave (
        input  avs_s1_address,
        input  avs_s1_read,
        input  avs_s1_write,
        input  avs_s1_writedata,
        output avs_s1_readdata,
        output avs_s1_waitrequest
    );
endinterface

// File: rtl/avalon_fp_mult_mc.sv
// Multi-channel Avalon-MM single-precision multiplier.
// NUM_CH channels share one fully pipelined multiplier; a {valid, ch} tag pipeline
// runs alongside it so each result lands in the channel that issued it.
// Denormal inputs are treated as zero and results too small to be normal flush to zero.
module avalon_fp_mult_mc #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned LATENCY = 11
) (
    input  logic               clk,
    input  logic               reset,
    avalon_fp_mult_mc_if.slave s1,
    output logic               ins_irq
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] StNone = 3'd0;
    localparam logic [2:0] StOvf  = 3'd1;
    localparam logic [2:0] StUdf  = 3'd2;
    localparam logic [2:0] StZero = 3'd3;
    localparam logic [2:0] StNan  = 3'd4;

    // Channel register file
    logic [31:0]       op1_q    [NUM_CH];
    logic [31:0]       op2_q    [NUM_CH];
    logic [31:0]       result_q [NUM_CH];
    logic [2:0]        status_q [NUM_CH];
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] irq_en_q;
    logic              irq_q;

    // Issue register feeding the multiplier
    logic              iss_vld_q;
    logic [CH_W-1:0]   iss_ch_q;
    logic [31:0]       iss_a_q;
    logic [31:0]       iss_b_q;

    // Tag and datapath pipelines
    logic              tag_vld_q [LATENCY];
    logic [CH_W-1:0]   tag_ch_q  [LATENCY];
    logic [31:0]       fp_res_q  [LATENCY];
    logic [2:0]        fp_st_q   [LATENCY];

    // Bus decode
    logic [CH_W-1:0] acc_ch;
    logic [2:0]      acc_reg;
    logic            ch_ok;
    logic            pend_sel;
    logic            rd_res;
    logic            wr_iss;
    logic            stall;
    logic            acc_rd;
    logic            acc_wr;
    logic [31:0]     rdata;

    assign acc_ch   = s1.avs_s1_address[CH_W+2:3];
    assign acc_reg  = s1.avs_s1_address[2:0];
    assign ch_ok    = 32'(acc_ch) < NUM_CH;
    assign pend_sel = ch_ok && pend_q[acc_ch];
    assign rd_res   = s1.avs_s1_read && ch_ok && (acc_reg == 3'd3);
    assign wr_iss   = s1.avs_s1_write && ch_ok && (acc_reg == 3'd2) && s1.avs_s1_writedata[0];
    assign stall    = reset && pend_sel && (rd_res || wr_iss);
    assign acc_rd   = reset && s1.avs_s1_read && ch_ok && !stall;
    assign acc_wr   = reset && s1.avs_s1_write && ch_ok && !stall;

    assign s1.avs_s1_waitrequest = stall;
    assign s1.avs_s1_readdata    = rdata;
    assign ins_irq               = irq_q;

    // Zero-wait read mux; unused registers and absent channels read as zero
    always_comb begin
        rdata = '0;
        if (reset && s1.avs_s1_read && ch_ok) begin
            case (acc_reg)
                3'd0:    rdata = op1_q[acc_ch];
                3'd1:    rdata = op2_q[acc_ch];
                3'd2:    rdata = {29'd0, irq_en_q[acc_ch], done_q[acc_ch], pend_q[acc_ch]};
                3'd3:    rdata = result_q[acc_ch];
                3'd4:    rdata = {29'd0, status_q[acc_ch]};
                default: rdata = '0;
            endcase
        end
    end

    // Multiplier datapath front end: classify, multiply significands, round to nearest even
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, p_sign;
    logic [47:0]       prod;
    logic signed [9:0] exp_s;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_f;
    logic [23:0]       mant;
    logic              guard, sticky, round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic              f_nan, f_ovf, f_udf, f_zero;
    logic [31:0]       mul_res;
    logic [2:0]        mul_st;

    always_comb begin
        a_nan  = (iss_a_q[30:23] == 8'hFF) && (iss_a_q[22:0] != 23'd0);
        b_nan  = (iss_b_q[30:23] == 8'hFF) && (iss_b_q[22:0] != 23'd0);
        a_inf  = (iss_a_q[30:23] == 8'hFF) && (iss_a_q[22:0] == 23'd0);
        b_inf  = (iss_b_q[30:23] == 8'hFF) && (iss_b_q[22:0] == 23'd0);
        a_zero = (iss_a_q[30:23] == 8'h00);
        b_zero = (iss_b_q[30:23] == 8'h00);
        p_sign = iss_a_q[31] ^ iss_b_q[31];

        prod  = {1'b1, iss_a_q[22:0]} * {1'b1, iss_b_q[22:0]};
        exp_s = $signed({2'b00, iss_a_q[30:23]}) + $signed({2'b00, iss_b_q[30:23]})
              - 10'sd127;
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_s + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_s;
        end
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {24'd0, round_up};
        // A rounding carry out of the significand bumps the exponent
        if (mant_r[24]) begin
            exp_f = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end else begin
            exp_f = exp_n;
            frac  = mant_r[22:0];
        end

        f_nan   = 1'b0;
        f_ovf   = 1'b0;
        f_udf   = 1'b0;
        f_zero  = 1'b0;
        mul_res = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            f_nan   = 1'b1;
            mul_res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            f_ovf   = 1'b1;
            mul_res = {p_sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            f_zero  = 1'b1;
            mul_res = {p_sign, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            f_ovf   = 1'b1;
            mul_res = {p_sign, 8'hFF, 23'd0};
        end else if (exp_f <= 10'sd0) begin
            f_udf   = 1'b1;
            f_zero  = 1'b1;
            mul_res = {p_sign, 31'd0};
        end else begin
            mul_res = {p_sign, exp_f[7:0], frac};
        end

        if (f_nan) begin
            mul_st = StNan;
        end else if (f_ovf) begin
            mul_st = StOvf;
        end else if (f_udf) begin
            mul_st = StUdf;
        end else if (f_zero) begin
            mul_st = StZero;
        end else begin
            mul_st = StNone;
        end
    end

    // Multiplier pipeline: enable is permanently on, so data simply shifts every cycle
    always_ff @(posedge clk) begin
        fp_res_q[0] <= mul_res;
        fp_st_q[0]  <= mul_st;
        for (int i = 1; i < int'(LATENCY); i++) begin
            fp_res_q[i] <= fp_res_q[i-1];
            fp_st_q[i]  <= fp_st_q[i-1];
        end
    end

    // Tag pipeline: tracks which channel owns each in-flight multiply
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_ch_q[i]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= iss_vld_q;
            tag_ch_q[0]  <= iss_ch_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ch_q[i]  <= tag_ch_q[i-1];
            end
        end
    end

    // Register file, issue and completion; completion is applied last so it wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                op1_q[c]    <= '0;
                op2_q[c]    <= '0;
                result_q[c] <= '0;
                status_q[c] <= '0;
            end
            done_q    <= '0;
            pend_q    <= '0;
            irq_en_q  <= '0;
            iss_vld_q <= 1'b0;
            iss_ch_q  <= '0;
            iss_a_q   <= '0;
            iss_b_q   <= '0;
        end else begin
            iss_vld_q <= 1'b0;
            if (acc_wr) begin
                case (acc_reg)
                    3'd0: op1_q[acc_ch] <= s1.avs_s1_writedata;
                    3'd1: op2_q[acc_ch] <= s1.avs_s1_writedata;
                    3'd2: begin
                        irq_en_q[acc_ch] <= s1.avs_s1_writedata[1];
                        if (s1.avs_s1_writedata[0]) begin
                            pend_q[acc_ch] <= 1'b1;
                            done_q[acc_ch] <= 1'b0;
                            iss_vld_q      <= 1'b1;
                            iss_ch_q       <= acc_ch;
                            iss_a_q        <= op1_q[acc_ch];
                            iss_b_q        <= op2_q[acc_ch];
                        end
                    end
                    default: ;
                endcase
            end
            if (acc_rd && (acc_reg == 3'd3)) begin
                done_q[acc_ch] <= 1'b0;
            end
            if (tag_vld_q[LATENCY-1]) begin
                result_q[tag_ch_q[LATENCY-1]] <= fp_res_q[LATENCY-1];
                status_q[tag_ch_q[LATENCY-1]] <= fp_st_q[LATENCY-1];
                done_q[tag_ch_q[LATENCY-1]]   <= 1'b1;
                pend_q[tag_ch_q[LATENCY-1]]   <= 1'b0;
            end
        end
    end

    // Level interrupt, one cycle behind the done flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(done_q & irq_en_q);
        end
    end
endmodule

// File: tb/tb_avalon_fp_mult_mc.sv
// Bench for avalon_fp_mult_mc: directed scenarios plus random bus traffic, checked
// against a transaction-level channel model and a real-arithmetic multiply reference.
module tb_avalon_fp_mult_mc;
    localparam int NUM_CH  = 4;
    localparam int LATENCY = 11;
    localparam int CH_W    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ins_irq;

    always #5 clk = ~clk;

    avalon_fp_mult_mc_if #(.CH_W(CH_W)) bus ();

    avalon_fp_mult_mc #(
        .NUM_CH (NUM_CH),
        .LATENCY(LATENCY)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s1     (bus.slave),
        .ins_irq(ins_irq)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Channel model
    logic [31:0] m_op1 [NUM_CH];
    logic [31:0] m_op2 [NUM_CH];
    logic [31:0] m_res [NUM_CH];
    logic [2:0]  m_st  [NUM_CH];
    logic [31:0] m_qa  [NUM_CH];
    logic [31:0] m_qb  [NUM_CH];
    bit          m_done[NUM_CH];
    bit          m_pend[NUM_CH];
    bit          m_en  [NUM_CH];
    int          m_due [NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference multiply: returns {status, result}
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        bit an, bn, ai, bi, az, bz, s;
        real p;
        logic [63:0] pb;
        int e;
        logic [23:0] f;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || (ai && bz) || (bi && az)) return {3'd4, 32'h7FC00000};
        if (ai || bi) return {3'd1, s, 8'hFF, 23'd0};
        if (az || bz) return {3'd3, s, 31'd0};
        p  = to_real(a) * to_real(b);
        pb = $realtobits(p);
        e  = int'(pb[62:52]) - 1023 + 127;
        f  = {1'b0, pb[51:29]};
        if (pb[28] && ((|pb[27:0]) || pb[29])) f = f + 24'd1;
        if (f[23]) begin
            e = e + 1;
            f = '0;
        end
        if (e >= 255) return {3'd1, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'd2, s, 31'd0};
        return {3'd0, s, 8'(e), f[22:0]};
    endfunction

    function automatic logic [31:0] model_read(input int ch, input int rg);
        case (rg)
            0: return m_op1[ch];
            1: return m_op2[ch];
            2: return {29'd0, m_en[ch], m_done[ch], m_pend[ch]};
            3: return m_res[ch];
            4: return {29'd0, m_st[ch]};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge, update the model for that edge and check the interrupt
    task automatic tick();
        bit irq_next;
        logic [34:0] r;
        irq_next = 1'b0;
        for (int c = 0; c < NUM_CH; c++) irq_next |= m_done[c] & m_en[c];
        @(posedge clk);
        cyc++;
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_op1[c] = '0; m_op2[c] = '0; m_res[c] = '0; m_st[c] = '0;
                m_done[c] = 0; m_pend[c] = 0; m_en[c] = 0;
            end
            irq_next = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_pend[c] && m_due[c] == cyc) begin
                    r = ref_mul(m_qa[c], m_qb[c]);
                    m_res[c]  = r[31:0];
                    m_st[c]   = r[34:32];
                    m_done[c] = 1;
                    m_pend[c] = 0;
                end
            end
        end
        #1;
        check_val("ins_irq", {31'd0, ins_irq}, {31'd0, irq_next});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One Avalon access, held until accepted; returns read data and wait-cycle count
    task automatic access(input bit wr, input int ch, input int rg, input logic [31:0] wd,
                          output logic [31:0] rd, output int waited);
        bit exp_wait, accepted, fin;
        waited = 0;
        fin    = 0;
        rd     = '0;
        bus.avs_s1_address   = {ch[CH_W-1:0], rg[2:0]};
        bus.avs_s1_read      = !wr;
        bus.avs_s1_write     = wr;
        bus.avs_s1_writedata = wd;
        while (!fin) begin
            #1;
            exp_wait = m_pend[ch] && ((!wr && rg == 3) || (wr && rg == 2 && wd[0]));
            check_val($sformatf("wait c%0d r%0d", ch, rg), {31'd0, bus.avs_s1_waitrequest},
                      {31'd0, exp_wait});
            if (!wr && !exp_wait)
                check_val($sformatf("rdata c%0d r%0d", ch, rg), bus.avs_s1_readdata,
                          model_read(ch, rg));
            rd       = bus.avs_s1_readdata;
            accepted = !bus.avs_s1_waitrequest;
            tick();
            if (accepted) begin
                fin = 1;
                if (wr) begin
                    case (rg)
                        0: m_op1[ch] = wd;
                        1: m_op2[ch] = wd;
                        2: begin
                            m_en[ch] = wd[1];
                            if (wd[0]) begin
                                m_pend[ch] = 1;
                                m_done[ch] = 0;
                                m_qa[ch]   = m_op1[ch];
                                m_qb[ch]   = m_op2[ch];
                                m_due[ch]  = cyc + LATENCY + 1;
                            end
                        end
                        default: ;
                    endcase
                end else if (rg == 3) begin
                    m_done[ch] = 0;
                end
            end else begin
                waited++;
                if (waited > LATENCY + 4) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stall timeout c%0d r%0d: waited %0d cycles, limit %0d",
                             ch, rg, waited, LATENCY + 4);
                    fin = 1;
                end
            end
        end
        bus.avs_s1_read  = 1'b0;
        bus.avs_s1_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_float();
        int k;
        k = $urandom_range(0, 15);
        case (k)
            0: return {1'($urandom), 31'd0};
            1: return {1'($urandom), 8'hFF, 23'd0};
            2: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            3: return {1'($urandom), 8'h00, 23'($urandom)};
            4, 5, 6, 7: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
        endcase
    endfunction

    logic [31:0] rd;
    int w;

    initial begin
        bus.avs_s1_address   = '0;
        bus.avs_s1_read      = 1'b0;
        bus.avs_s1_write     = 1'b0;
        bus.avs_s1_writedata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_op1[c] = '0; m_op2[c] = '0; m_res[c] = '0; m_st[c] = '0; m_qa[c] = '0;
            m_qb[c] = '0; m_done[c] = 0; m_pend[c] = 0; m_en[c] = 0; m_due[c] = 0;
        end
        reset = 1'b0;
        idle(2);
        #1;
        check_val("reset rdata", bus.avs_s1_readdata, 32'd0);
        check_val("reset wait", {31'd0, bus.avs_s1_waitrequest}, 32'd0);
        reset = 1'b1;
        idle(1);

        // Every register of every channel reads zero after reset
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 8; r++) begin
                access(0, c, r, 0, rd, w);
                check_val("t1 zero", rd, 32'd0);
            end

        // 2.0 x 3.0 with an immediately stalled result read
        access(1, 0, 0, 32'h40000000, rd, w);
        access(1, 0, 1, 32'h40400000, rd, w);
        access(1, 0, 2, 32'h1, rd, w);
        access(0, 0, 3, 0, rd, w);
        check_val("t2 result", rd, 32'h40C00000);
        check_val("t2 stall cycles", w, LATENCY + 1);
        access(0, 0, 4, 0, rd, w);
        check_val("t2 status", rd, 32'd0);
        access(0, 0, 2, 0, rd, w);
        check_val("t2 ctrl", rd, 32'd0);

        // Back-to-back issues across all four channels
        access(1, 0, 0, 32'h3FC00000, rd, w); access(1, 0, 1, 32'h40000000, rd, w);
        access(1, 1, 0, 32'h00000000, rd, w); access(1, 1, 1, 32'h40A00000, rd, w);
        access(1, 2, 0, 32'h7FC00000, rd, w); access(1, 2, 1, 32'h3F800000, rd, w);
        access(1, 3, 0, 32'h7F000000, rd, w); access(1, 3, 1, 32'h7F000000, rd, w);
        for (int c = 0; c < 4; c++) access(1, c, 2, 32'h1, rd, w);
        // After the first completion edge: ch0 done, ch1 still pending
        idle(LATENCY - 3);
        access(0, 1, 2, 0, rd, w);
        check_val("t3 ch1 pending", rd, 32'h1);
        access(0, 0, 2, 0, rd, w);
        check_val("t3 ch0 done", rd, 32'h2);
        idle(3);
        access(0, 0, 3, 0, rd, w); check_val("t3 r0", rd, 32'h40400000);
        check_val("t3 no stall", w, 0);
        access(0, 1, 3, 0, rd, w); check_val("t3 r1", rd, 32'h00000000);
        access(0, 1, 4, 0, rd, w); check_val("t3 s1", rd, 32'd3);
        access(0, 2, 3, 0, rd, w); check_val("t3 r2", rd, 32'h7FC00000);
        access(0, 2, 4, 0, rd, w); check_val("t3 s2", rd, 32'd4);
        access(0, 3, 3, 0, rd, w); check_val("t3 r3", rd, 32'h7F800000);
        access(0, 3, 4, 0, rd, w); check_val("t3 s3", rd, 32'd1);

        // Interrupt enabled then disabled on ch1 (irq checked every cycle by the model)
        access(1, 1, 0, 32'h40000000, rd, w);
        access(1, 1, 1, 32'h40000000, rd, w);
        access(1, 1, 2, 32'h3, rd, w);
        idle(LATENCY + 3);
        check_val("t4 irq high", {31'd0, ins_irq}, 32'd1);
        access(0, 1, 3, 0, rd, w);
        check_val("t4 r", rd, 32'h40800000);
        idle(1);
        check_val("t4 irq low", {31'd0, ins_irq}, 32'd0);
        access(1, 1, 2, 32'h1, rd, w);
        idle(LATENCY + 4);
        check_val("t4 irq off", {31'd0, ins_irq}, 32'd0);

        // Re-issue while pending stalls; second issue uses the updated operand
        access(1, 2, 0, 32'h40000000, rd, w);
        access(1, 2, 1, 32'h40400000, rd, w);
        access(1, 2, 2, 32'h1, rd, w);
        access(1, 2, 0, 32'h40800000, rd, w);
        access(1, 2, 2, 32'h1, rd, w);
        check_val("t5 reissue stall", w, LATENCY);
        access(0, 2, 3, 0, rd, w);
        check_val("t5 result", rd, 32'h41400000);
        check_val("t5 stall cycles", w, LATENCY + 1);

        // Reset mid-flight discards the multiply
        access(1, 0, 2, 32'h1, rd, w);
        idle(3);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(LATENCY + 4);
        access(0, 0, 2, 0, rd, w); check_val("t6 ctrl", rd, 32'd0);
        access(0, 0, 3, 0, rd, w); check_val("t6 result", rd, 32'd0);
        check_val("t6 no stall", w, 0);
        access(0, 0, 6, 0, rd, w); check_val("t6 reg6", rd, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int ch, rg, k;
            logic [31:0] wd;
            ch = $urandom_range(0, NUM_CH - 1);
            k  = $urandom_range(0, 9);
            if (k < 4) begin
                rg = $urandom_range(0, 1);
                wd = rand_float();
                access(1, ch, rg, wd, rd, w);
            end else if (k < 6) begin
                access(1, ch, 2, 32'($urandom_range(0, 3)), rd, w);
            end else if (k < 7) begin
                access(1, ch, $urandom_range(3, 7), $urandom, rd, w);
            end else begin
                access(0, ch, $urandom_range(0, 7), 0, rd, w);
            end
        end
        idle(LATENCY + 3);
        for (int c = 0; c < NUM_CH; c++) begin
            access(0, c, 3, 0, rd, w);
            access(0, c, 4, 0, rd, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d cycles run", cyc);
        $fatal(1, "watchdog");
    end
endmodule
